// File: rtl/rs_issue_select.sv
// rs_issue_select: single-slot issue stage for a reservation station.
// Picks one ready entry per cycle, grants it combinationally and captures its
// operands/control into the issue register on the next rising edge.
// Optional feature: define RS_ISSUE_RR_EN for round-robin selection; the default
// build uses fixed lowest-index-first priority with no pointer state.
module rs_issue_select #(
   parameter int unsigned WIDTH = 31,
   parameter int unsigned RS    = 3,
   parameter int unsigned CTRL  = 3,
   localparam int unsigned IDXW = (RS > 0) ? $clog2(RS + 1) : 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [RS:0]              req,
   input  logic [RS:0][WIDTH:0]     src1,
   input  logic [RS:0][WIDTH:0]     src2,
   input  logic [RS:0][CTRL:0]      ctrl,
   input  logic                     flush,
   input  logic                     iss_ready,
   output logic [RS:0]              grant,
   output logic                     iss_valid,
   output logic [WIDTH:0]           operand1,
   output logic [WIDTH:0]           operand2,
   output logic [CTRL:0]            ctrlOut,
   output logic [IDXW-1:0]          iss_idx
);

   logic            r_valid;
   logic [WIDTH:0]  r_op1;
   logic [WIDTH:0]  r_op2;
   logic [CTRL:0]   r_ctrl;
   logic [IDXW-1:0] r_idx;

   logic            w_load;
   logic            w_found;
   logic [IDXW-1:0] w_win;
   logic [IDXW-1:0] w_cand;

   // The slot can take a new entry when empty or draining, unless squashed
   assign w_load = (!r_valid || iss_ready) && !flush;

`ifdef RS_ISSUE_RR_EN
   logic [IDXW-1:0] r_ptr;
   int              w_j;

   // Round-robin search starting at the pointer, wrapping past entry RS
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      w_j     = 0;
      for (int k = 0; k <= int'(RS); k++) begin
         w_j = int'(r_ptr) + k;
         if (w_j > int'(RS)) begin
            w_j = w_j - int'(RS) - 1;
         end
         w_cand = IDXW'(w_j);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   // Pointer moves just past the winner only when a grant actually happens
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ptr <= '0;
      end else if (w_load && w_found) begin
         r_ptr <= (w_win == IDXW'(RS)) ? '0 : w_win + IDXW'(1);
      end
   end
`else
   // Fixed priority: lowest-index requesting entry wins
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k <= int'(RS); k++) begin
         w_cand = IDXW'(k);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end
`endif

   // One-hot grant; gated by reset so it reads zero while resetn is low
   always_comb begin
      grant = '0;
      if (resetn && w_load && w_found) begin
         grant[w_win] = 1'b1;
      end
   end

   // Issue register: load winner, clear on empty load or flush, hold on stall
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_op1   <= '0;
         r_op2   <= '0;
         r_ctrl  <= '0;
         r_idx   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= w_found;
         if (w_found) begin
            r_op1  <= src1[w_win];
            r_op2  <= src2[w_win];
            r_ctrl <= ctrl[w_win];
            r_idx  <= w_win;
         end
      end
   end

   assign iss_valid = r_valid;
   assign operand1  = r_op1;
   assign operand2  = r_op2;
   assign ctrlOut   = r_ctrl;
   assign iss_idx   = r_idx;

endmodule

// File: tb/tb_rs_issue_select.sv
// Testbench for rs_issue_select (RS=3, WIDTH=31, CTRL=3). Directed vectors;
// granted entries are queued as expected transfers and a monitor compares them
// whenever the issue register hands off to the functional unit.
module tb_rs_issue_select;

   logic             clk = 1'b0;
   logic             resetn;
   logic [3:0]       req;
   logic [3:0][31:0] src1;
   logic [3:0][31:0] src2;
   logic [3:0][3:0]  ctrl;
   logic             flush;
   logic             iss_ready;
   logic [3:0]       grant;
   logic             iss_valid;
   logic [31:0]      operand1;
   logic [31:0]      operand2;
   logic [3:0]       ctrlOut;
   logic [1:0]       iss_idx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] o1;
      logic [31:0] o2;
      logic [3:0]  c;
      logic [1:0]  idx;
   } exp_t;

   exp_t q[$];

   rs_issue_select #(
      .WIDTH(31),
      .RS   (3),
      .CTRL (3)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .req      (req),
      .src1     (src1),
      .src2     (src2),
      .ctrl     (ctrl),
      .flush    (flush),
      .iss_ready(iss_ready),
      .grant    (grant),
      .iss_valid(iss_valid),
      .operand1 (operand1),
      .operand2 (operand2),
      .ctrlOut  (ctrlOut),
      .iss_idx  (iss_idx)
   );

   always #5 clk = ~clk;

   // Per-entry stimulus data
   function automatic logic [31:0] d1(input int i);
      return (i == 1) ? 32'hA : 32'h1000 + 32'(i);
   endfunction

   function automatic logic [31:0] d2(input int i);
      return 32'h2000 + 32'(i);
   endfunction

   function automatic logic [3:0] dc(input int i);
      return 4'h5 + 4'(i);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs at posedge+2, check grant at posedge+4,
   // queue the expected transfer, return at the next posedge+2
   task automatic step(input logic [3:0] r, input logic fl, input logic rdy,
                       input logic [3:0] eg, input string nm);
      exp_t e;
      req       = r;
      flush     = fl;
      iss_ready = rdy;
      #2;
      chk({nm, " grant"}, {28'h0, grant}, {28'h0, eg});
      for (int k = 0; k < 4; k++) begin
         if (eg[k]) begin
            e.o1  = d1(k);
            e.o2  = d2(k);
            e.c   = dc(k);
            e.idx = 2'(k);
            q.push_back(e);
         end
      end
      @(posedge clk);
      #2;
   endtask

   // Assert reset, check outputs read zero before any edge, release
   task automatic do_reset(input string nm);
      resetn    = 1'b0;
      req       = 4'b1111;
      iss_ready = 1'b1;
      flush     = 1'b0;
      #1;
      chk({nm, " valid"}, {31'h0, iss_valid}, 32'h0);
      chk({nm, " op1"}, operand1, 32'h0);
      chk({nm, " op2"}, operand2, 32'h0);
      chk({nm, " ctrl"}, {28'h0, ctrlOut}, 32'h0);
      chk({nm, " idx"}, {30'h0, iss_idx}, 32'h0);
      chk({nm, " grant"}, {28'h0, grant}, 32'h0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      req    = 4'b0000;
   endtask

   // Monitor: a transfer happens on each edge where iss_valid && iss_ready
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (iss_valid === 1'b1 && iss_ready === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL xfer unexpected: got idx %0d expected no transfer", iss_idx);
            end else begin
               e = q.pop_front();
               chk("xfer op1", operand1, e.o1);
               chk("xfer op2", operand2, e.o2);
               chk("xfer ctrl", {28'h0, ctrlOut}, {28'h0, e.c});
               chk("xfer idx", {30'h0, iss_idx}, {30'h0, e.idx});
            end
         end
      end
   end

   initial begin : stim
      logic [3:0] g30[5];
`ifdef RS_ISSUE_RR_EN
      g30 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      g30 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      for (int i = 0; i < 4; i++) begin
         src1[i] = d1(i);
         src2[i] = d2(i);
         ctrl[i] = dc(i);
      end
      resetn    = 1'b1;
      req       = 4'b0000;
      flush     = 1'b0;
      iss_ready = 1'b0;
      #1;
      do_reset("rst0");

      // Single request, one-cycle latency
      step(4'b0110, 1'b0, 1'b1, 4'b0010, "first");
      chk("first valid", {31'h0, iss_valid}, 32'h1);
      chk("first op1", operand1, 32'hA);
      chk("first idx", {30'h0, iss_idx}, 32'h1);

      // No requests: slot empties
      step(4'b0000, 1'b0, 1'b1, 4'b0000, "noreq");
      chk("noreq valid", {31'h0, iss_valid}, 32'h0);

      // Back-to-back issue with all entries requesting
      do_reset("rst1");
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b0, 1'b1, g30[i], "allreq");
      end

      // Stall for three cycles holding entry 0
      for (int i = 0; i < 3; i++) begin
         step(4'b1000, 1'b0, 1'b0, 4'b0000, "stall");
         chk("stall valid", {31'h0, iss_valid}, 32'h1);
         chk("stall op1", operand1, 32'h1000);
         chk("stall op2", operand2, 32'h2000);
         chk("stall ctrl", {28'h0, ctrlOut}, 32'h5);
         chk("stall idx", {30'h0, iss_idx}, 32'h0);
      end
      step(4'b1000, 1'b0, 1'b1, 4'b1000, "unstall");

      // Flush discards the held entry 3 and leaves the pointer alone
      step(4'b0011, 1'b1, 1'b0, 4'b0000, "flush");
      q.delete(q.size() - 1);
      chk("flush valid", {31'h0, iss_valid}, 32'h0);
      step(4'b0011, 1'b0, 1'b1, 4'b0001, "postflush");

      // Reset in the middle of a stall discards entry 2
      step(4'b0100, 1'b0, 1'b1, 4'b0100, "preload");
      step(4'b0000, 1'b0, 1'b0, 4'b0000, "midstall");
      chk("midstall valid", {31'h0, iss_valid}, 32'h1);
      chk("midstall idx", {30'h0, iss_idx}, 32'h2);
      q.delete(q.size() - 1);
      do_reset("rst2");

      step(4'b1111, 1'b0, 1'b1, 4'b0001, "postrst");
      step(4'b0000, 1'b0, 1'b1, 4'b0000, "drain");
      step(4'b0000, 1'b0, 1'b1, 4'b0000, "idle");
      chk("queue empty", 32'(q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
